seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//  Time-multiplexed scan driver for the 8-digit common-anode seven-segment display.
//  Sits directly downstream of the APB GPIO block and consumes its eight latched segment
//  bytes (gpio_seg_0..7).
//  Drives one digit at a time onto a shared segment bus and its active-low anode line.
//  Provides a blanking gap between digits, per-digit enables and a 16-level brightness PWM.
// PARAMETERS
//  DIGIT_CYCLES  2048  clocks per digit slot; legal range BLANK_CYCLES+16 .. 65535
//  BLANK_CYCLES  64    clocks at the start of each slot with all anodes off; legal range >=1
// PORTS
//  clock       in   1   system clock
//  reset       in   1   asynchronous, active-high
//  seg_0..7    in   8   segment byte per digit, active-low; bit7=a .. bit1=g, bit0=dp
//  digit_en    in   8   bit i=1 enables digit i; a disabled digit stays dark for its slot
//  brightness  in   4   duty in 16ths of each show phase; 0=dark, 15=fully on
//  an          out  8   anode select, active-low, at most one bit low at any time
//  seg_out     out  8   shared segment bus, active-low
//  scan_idx    out  3   digit index of the current slot
//  frame_done  out  1   one-cycle pulse in the last clock of slot 7
// BEHAVIOUR
//  - Reset: an=8'hFF, seg_out=8'hFF, scan_idx=0, frame_done=0.
//    Slot counter = 0, state BLANK, PWM counter = 0, capture registers = 8'hFF.
//  - Reset asserted mid-operation forces all reset values immediately (asynchronous).
//    After release, slot 0 restarts from cycle 0.
//  - Slot counter cnt runs 0..DIGIT_CYCLES-1, then wraps to 0.
//    On wrap, scan_idx increments mod 8 (7->0).
//  - Frame period = 8*DIGIT_CYCLES clocks. Timing is independent of digit_en and brightness.
//  - FSM has two states:
//    - BLANK: cnt < BLANK_CYCLES. Outputs an=8'hFF, seg_out=8'hFF.
//    - SHOW: cnt >= BLANK_CYCLES.
//    - BLANK->SHOW when cnt==BLANK_CYCLES-1.
//    - SHOW->BLANK when cnt==DIGIT_CYCLES-1.
//  - Capture: at the edge where cnt==BLANK_CYCLES-1, the block registers:
//    - seg_<scan_idx>
//    - digit_en[scan_idx]
//    - brightness
//    Changes to these inputs during SHOW have no effect until the next slot (no tearing).
//  - PWM: a 4-bit counter p resets to 0 on SHOW entry and increments every SHOW cycle,
//    wrapping 15->0.
//    The digit is lit when captured_en==1 and (captured_brightness==15 or p < captured_brightness).
//  - Lit: an = ~(8'b1 << scan_idx), seg_out = captured segment byte.
//  - Unlit: an = 8'hFF, seg_out = 8'hFF.
//  - an and seg_out are registered and change on the same edge, with no glitch between them.
//  - First lit cycle of slot i: an[i] goes low on the edge ending cycle cnt==BLANK_CYCLES-1
//    (one-cycle latency after capture decode).
//    an returns to 8'hFF on the edge where cnt wraps to 0.
//  - frame_done is high exactly while scan_idx==7 and cnt==DIGIT_CYCLES-1.
//  - The counter width is sized for DIGIT_CYCLES. No arithmetic overflow is permitted.
// TESTING
//  Run with DIGIT_CYCLES=32 and BLANK_CYCLES=4.
//  1. Reset check: release reset with digit_en=FF, brightness=15, seg_k=8'h03.
//     -> an=FF for 4 cycles, then an=FE and seg_out=03 for 28 cycles.
//     -> Next slot: an=FF for 4 cycles, then an=FD.
//  2. Full frame: seg_k = {k,k,k,k,k,k,k,k} (distinct bytes).
//     -> Slot k shows an=~(1<<k) with seg_out=seg_k.
//     -> frame_done pulses once every 256 cycles, at scan_idx=7, cnt=31.
//  3. Enables: digit_en=8'b1010_1010.
//     -> Slots 0, 2, 4, 6 keep an=FF for the whole slot; slots 1, 3, 5, 7 light.
//     -> Frame period stays 256 cycles.
//  4. Brightness: brightness=4 -> in each SHOW phase, lit for p=0..3, dark for p=4..15,
//     then lit for p=0..3 and dark for p=4..11 (28 SHOW cycles, 8 lit).
//     brightness=0 -> never lit.
//  5. No tearing: change seg_3 from 8'h9F to 8'h25 mid-SHOW of slot 3.
//     -> seg_out holds 9F until slot end; 25 appears in slot 3 of the next frame.
//  6. Mid-operation reset: assert reset during SHOW of slot 5.
//     -> an=FF, seg_out=FF, scan_idx=0 immediately (without waiting for a clock edge).
//     -> After release, 4 blank cycles, then digit 0 is shown.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Connection bundle between the GPIO segment latches and the seven-segment scan driver.
// master = segment data source, slave = scan driver.
interface seg_scan_driver_if;
  logic [7:0] seg_0;
  logic [7:0] seg_1;
  logic [7:0] seg_2;
  logic [7:0] seg_3;
  logic [7:0] seg_4;
  logic [7:0] seg_5;
  logic [7:0] seg_6;
  logic [7:0] seg_7;
  logic [7:0] digit_en;
  logic [3:0] brightness;
  logic [7:0] an;
  logic [7:0] seg_out;
  logic [2:0] scan_idx;
  logic       frame_done;

  modport master (
    output seg_0, seg_1, seg_2, seg_3, seg_4, seg_5, seg_6, seg_7,
    output digit_en, brightness,
    input  an, seg_out, scan_idx, frame_done
  );

  modport slave (
    input  seg_0, seg_1, seg_2, seg_3, seg_4, seg_5, seg_6, seg_7,
    input  digit_en, brightness,
    output an, seg_out, scan_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode display: one digit per slot,
// a blanking gap at the start of each slot, per-digit enables and 16-level PWM brightness.
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 2048,
  parameter int BLANK_CYCLES = 64
) (
  input logic            clock,
  input logic            reset,
  seg_scan_driver_if.slave bus
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_CAPT = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [3:0]    pwm_reg, pwm_next;
  logic [7:0]    cap_seg_reg, cap_seg_next;
  logic          cap_en_reg, cap_en_next;
  logic [3:0]    cap_bri_reg, cap_bri_next;
  logic [7:0]    an_reg, an_next;
  logic [7:0]    seg_out_reg, seg_out_next;

  logic          slot_end;
  logic          capture;
  logic [7:0]    seg_sel;
  logic [7:0]    an_lit;
  logic          lit_next;

  assign slot_end = (cnt_reg == CNT_LAST);
  assign capture  = (cnt_reg == CNT_CAPT);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_an_decode
      assign an_lit[gi] = (idx_reg != 3'(gi));
    end
  endgenerate

  always_comb begin
    seg_sel = 8'hFF;
    case (idx_reg)
      3'd0: seg_sel = bus.seg_0;
      3'd1: seg_sel = bus.seg_1;
      3'd2: seg_sel = bus.seg_2;
      3'd3: seg_sel = bus.seg_3;
      3'd4: seg_sel = bus.seg_4;
      3'd5: seg_sel = bus.seg_5;
      3'd6: seg_sel = bus.seg_6;
      default: seg_sel = bus.seg_7;
    endcase
  end

  always_comb begin
    cnt_next = slot_end ? '0 : cnt_reg + CW'(1);
    idx_next = slot_end ? idx_reg + 3'd1 : idx_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      idx_reg <= 3'd0;
    end else begin
      cnt_reg <= cnt_next;
      idx_reg <= idx_next;
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= BLANK;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BLANK:   if (capture)  state_next = SHOW;
      SHOW:    if (slot_end) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Output logic: the capture edge also loads the first lit cycle, so it looks at the
  // live inputs being captured rather than the (not yet updated) capture registers.
  always_comb begin
    pwm_next     = (state_reg == SHOW) ? pwm_reg + 4'd1 : 4'd0;
    cap_seg_next = capture ? seg_sel : cap_seg_reg;
    cap_en_next  = capture ? bus.digit_en[idx_reg] : cap_en_reg;
    cap_bri_next = capture ? bus.brightness : cap_bri_reg;
    lit_next     = (state_next == SHOW) && cap_en_next &&
                   ((cap_bri_next == 4'hF) || (pwm_next < cap_bri_next));
    an_next      = lit_next ? an_lit : 8'hFF;
    seg_out_next = lit_next ? cap_seg_next : 8'hFF;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_reg     <= 4'd0;
      cap_seg_reg <= 8'hFF;
      cap_en_reg  <= 1'b0;
      cap_bri_reg <= 4'd0;
      an_reg      <= 8'hFF;
      seg_out_reg <= 8'hFF;
    end else begin
      pwm_reg     <= pwm_next;
      cap_seg_reg <= cap_seg_next;
      cap_en_reg  <= cap_en_next;
      cap_bri_reg <= cap_bri_next;
      an_reg      <= an_next;
      seg_out_reg <= seg_out_next;
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg_out    = seg_out_reg;
  assign bus.scan_idx   = idx_reg;
  assign bus.frame_done = (idx_reg == 3'd7) && slot_end;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed phases plus random input churn, every cycle checked
// against a slot/cycle model derived from absolute time since reset release.
module tb_seg_scan_driver;
  localparam int DC = 32;
  localparam int BC = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] seg_v [8];
  logic [7:0] en_v;
  logic [3:0] bri_v;

  int checks = 0;
  int failures = 0;
  int t = 0;

  logic [7:0] snap_seg = 8'hFF;
  logic       snap_en = 1'b0;
  logic [3:0] snap_bri = 4'd0;

  seg_scan_driver_if bus();

  assign bus.seg_0      = seg_v[0];
  assign bus.seg_1      = seg_v[1];
  assign bus.seg_2      = seg_v[2];
  assign bus.seg_3      = seg_v[3];
  assign bus.seg_4      = seg_v[4];
  assign bus.seg_5      = seg_v[5];
  assign bus.seg_6      = seg_v[6];
  assign bus.seg_7      = seg_v[7];
  assign bus.digit_en   = en_v;
  assign bus.brightness = bri_v;

  seg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Compare the current cycle against the model, record what the DUT captures, advance.
  task automatic tick();
    int cnt;
    int idx;
    int p;
    logic lit;
    logic [7:0] exp_an;
    logic [7:0] exp_seg;
    cnt = t % DC;
    idx = (t / DC) % 8;
    lit = 1'b0;
    if (cnt >= BC && snap_en) begin
      p = (cnt - BC) % 16;
      lit = (snap_bri == 4'd15) || (p < int'(snap_bri));
    end
    exp_an  = lit ? ~(8'd1 << idx) : 8'hFF;
    exp_seg = lit ? snap_seg : 8'hFF;
    check("an", bus.an, exp_an);
    check("seg_out", bus.seg_out, exp_seg);
    check("scan_idx", bus.scan_idx, idx);
    check("frame_done", bus.frame_done, (idx == 7 && cnt == DC - 1) ? 1 : 0);
    if (cnt == BC - 1) begin
      snap_seg = seg_v[idx];
      snap_en  = en_v[idx];
      snap_bri = bri_v;
    end
    if (cnt == DC - 1)
      $display("slot t=%0d idx=%0d seg=%h en=%0b bri=%0d", t, idx, snap_seg, snap_en, snap_bri);
    @(negedge clock);
    t++;
  endtask

  task automatic run_until(input int idx, input int cnt);
    for (int i = 0; i <= 8 * DC; i++) begin
      if (((t / DC) % 8) == idx && (t % DC) == cnt) return;
      tick();
    end
    check("run_until_timeout", 0, 1);
  endtask

  initial begin
    en_v  = 8'hFF;
    bri_v = 4'd15;
    for (int k = 0; k < 8; k++) seg_v[k] = 8'h03;
    repeat (3) @(negedge clock);
    check("rst_an", bus.an, 8'hFF);
    check("rst_seg_out", bus.seg_out, 8'hFF);
    check("rst_scan_idx", bus.scan_idx, 0);
    check("rst_frame_done", bus.frame_done, 0);
    reset = 1'b0;
    t = 0;

    // Reset check: two slots of 03 on all digits
    repeat (2 * DC) tick();

    // Full frame with distinct bytes
    for (int k = 0; k < 8; k++) seg_v[k] = 8'(k * 32) | 8'($urandom_range(0, 31));
    repeat (8 * DC) tick();

    // Alternate enables
    en_v = 8'hAA;
    repeat (8 * DC) tick();

    // Brightness 4 then 0
    en_v  = 8'hFF;
    bri_v = 4'd4;
    repeat (8 * DC) tick();
    bri_v = 4'd0;
    repeat (8 * DC) tick();
    bri_v = 4'd15;

    // No tearing on slot 3
    seg_v[3] = 8'h9F;
    run_until(2, 0);
    run_until(3, 10);
    seg_v[3] = 8'h25;
    check("tear_hold", bus.seg_out, 8'h9F);
    run_until(4, 0);
    run_until(3, 10);
    check("tear_next", bus.seg_out, 8'h25);

    // Random churn
    for (int i = 0; i < 4 * 8 * DC; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: seg_v[$urandom_range(0, 7)] = 8'($urandom);
          1: en_v = 8'($urandom);
          default: bri_v = 4'($urandom_range(0, 15));
        endcase
      end
      tick();
    end

    // Asynchronous reset during SHOW of slot 5
    en_v  = 8'hFF;
    bri_v = 4'd15;
    run_until(6, 0);
    run_until(5, 12);
    #2 reset = 1'b1;
    #1;
    check("async_an", bus.an, 8'hFF);
    check("async_seg_out", bus.seg_out, 8'hFF);
    check("async_scan_idx", bus.scan_idx, 0);
    check("async_frame_done", bus.frame_done, 0);
    @(negedge clock);
    reset = 1'b0;
    t = 0;
    snap_en = 1'b0;
    repeat (2 * DC) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
